obstacle_scroller: RTL and testbench

- Scrolls one obstacle sprite (small cactus, large cactus or bird) from the right screen edge to the left.
- Sprite is selected per run from a shared sprite ROM; bottom edge is anchored at a fixed row.
- Sits between the VGA pixel address generator and the colour mux. Supplies the registered pixel colour and an opaque-pixel flag that the collision logic uses.
- Successor to the single-sprite cactus block: multiple variants, variable scroll step, one clock with a scroll-tick enable, a proper start/done handshake and an aligned ROM-latency pipeline.

---
 rtl/obstacle_pkg.sv | 45 ++++
 rtl/obstacle_pix_pipe.sv | 65 ++++++
 rtl/obstacle_scroller.sv | 92 +++++++++
 tb/tb_obstacle_scroller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared constants, sprite indices and FSM encoding for the obstacle scroller.
// Build option OBSTACLE_TRANSPARENT_EN makes TRANSPARENT_KEY pixels see-through.
package obstacle_pkg;

  localparam int SPR_W    = 16;
  localparam int SPR_H    = 16;
  localparam int NUM_SPR  = 4;
  localparam int SEL_W    = 2;
  localparam int COLNUM   = 640;
  localparam int ROW_BASE = 130;
  localparam int ADDR_W   = 16;
  localparam int POS_W    = 12;
  localparam int STEP_W   = 4;
  localparam int COL_W    = 10;
  localparam int ROW_W    = 9;
  localparam int PIX_W    = 12;

  localparam logic [PIX_W-1:0] BG_COLOR        = 12'hfff;
  localparam logic [PIX_W-1:0] TRANSPARENT_KEY = 12'hfff;

  // pos value at which the sprite has completely left the screen
  localparam logic [POS_W-1:0] POS_END = POS_W'(COLNUM + SPR_W);

  localparam logic [SEL_W-1:0] SPR_CACTUS_S = 2'd0;
  localparam logic [SEL_W-1:0] SPR_CACTUS_L = 2'd1;
  localparam logic [SEL_W-1:0] SPR_BIRD_A   = 2'd2;
  localparam logic [SEL_W-1:0] SPR_BIRD_B   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SCROLL = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Advance pos by step, clamped to POS_END.
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] pos,
                                               input logic [STEP_W-1:0] step);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + {{(POS_W+1-STEP_W){1'b0}}, step};
    if (sum >= {1'b0, POS_END}) return POS_END;
    return sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/obstacle_pix_pipe.sv
// Window test, sprite ROM address math and the two-stage colour/hit alignment.
// With OBSTACLE_TRANSPARENT_EN defined, TRANSPARENT_KEY pixels are not drawn or hit.
module obstacle_pix_pipe
  import obstacle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [COL_W-1:0]  col_addr,
  input  logic [ROW_W-1:0]  row_addr,
  input  logic [POS_W-1:0]  pos,
  input  logic [SEL_W-1:0]  sel_q,
  input  logic              active,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [PIX_W-1:0]  dout,
  output logic              pix_hit
);

  localparam logic [POS_W-1:0] WIN_LO  = POS_W'(COLNUM);
  localparam logic [ROW_W-1:0] ROW_TOP = ROW_W'(ROW_BASE - SPR_H + 1);
  localparam logic [ROW_W-1:0] ROW_BOT = ROW_W'(ROW_BASE);

  logic [POS_W-1:0] col_sum;
  logic [POS_W-1:0] col_off;
  logic [ROW_W-1:0] row_off;
  logic             in_win;
  logic             win_d;
  logic             opaque;

  // col+pos lands inside [COLNUM, COLNUM+SPR_W) exactly when the column is on the sprite
  always_comb begin
    col_sum  = {{(POS_W-COL_W){1'b0}}, col_addr} + pos;
    col_off  = col_sum - WIN_LO;
    row_off  = row_addr - ROW_TOP;
    in_win   = active
            && (col_sum >= WIN_LO) && (col_sum < POS_END)
            && (row_addr >= ROW_TOP) && (row_addr <= ROW_BOT);
    rom_addr = '0;
    if (in_win) begin
      rom_addr = ADDR_W'(sel_q) * ADDR_W'(SPR_W * SPR_H)
               + ADDR_W'(row_off) * ADDR_W'(SPR_W)
               + ADDR_W'(col_off);
    end
  end

`ifdef OBSTACLE_TRANSPARENT_EN
  assign opaque = (rom_data != TRANSPARENT_KEY);
`else
  assign opaque = 1'b1;
`endif

  // win_d lines up with rom_data, which arrives one cycle after rom_addr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_d   <= 1'b0;
      pix_hit <= 1'b0;
      dout    <= BG_COLOR;
    end else begin
      win_d   <= in_win;
      pix_hit <= win_d && opaque;
      dout    <= (win_d && opaque) ? rom_data : BG_COLOR;
    end
  end

endmodule

// File: rtl/obstacle_scroller.sv
// Scrolls one obstacle sprite right-to-left; owns the run FSM and scroll position.
// Build option OBSTACLE_TRANSPARENT_EN enables pixel-accurate transparency.
module obstacle_scroller
  import obstacle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel,
  input  logic [STEP_W-1:0] step,
  input  logic [COL_W-1:0]  col_addr,
  input  logic [ROW_W-1:0]  row_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [PIX_W-1:0]  dout,
  output logic              pix_hit,
  output logic              busy,
  output logic              done
);

  state_t             state, state_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [STEP_W-1:0]  step_q, step_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pos    <= POS_END;
      sel_q  <= '0;
      step_q <= STEP_W'(1);
    end else begin
      state  <= state_n;
      pos    <= pos_n;
      sel_q  <= sel_n;
      step_q <= step_n;
    end
  end

  // start overrides everything, including a coincident tick
  always_comb begin
    state_n = state;
    pos_n   = pos;
    sel_n   = sel_q;
    step_n  = step_q;
    if (start) begin
      state_n = ARMED;
      pos_n   = '0;
      sel_n   = sel;
      step_n  = (step == '0) ? STEP_W'(1) : step;
    end else begin
      case (state)
        IDLE: ;
        ARMED: begin
          if (tick) begin
            state_n = SCROLL;
            pos_n   = sat_add(pos, step_q);
          end
        end
        SCROLL: begin
          if (tick) begin
            pos_n = sat_add(pos, step_q);
            if (pos_n == POS_END) state_n = DONE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARMED) || (state == SCROLL);
    done = (state == DONE);
  end

  obstacle_pix_pipe u_pipe (
    .clk      (clk),
    .rst      (rst),
    .col_addr (col_addr),
    .row_addr (row_addr),
    .pos      (pos),
    .sel_q    (sel_q),
    .active   (state != IDLE),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .dout     (dout),
    .pix_hit  (pix_hit)
  );

endmodule

// File: tb/tb_obstacle_scroller.sv
// Randomised scoreboard bench for obstacle_scroller against a geometric sprite model.
// Honours OBSTACLE_TRANSPARENT_EN the same way as the design build.
module tb_obstacle_scroller;
  import obstacle_pkg::*;

  localparam int W = 45; // {due_cycle[31:0], hit, colour[11:0]}

  logic        clk, rst, tick, start;
  logic [1:0]  sel;
  logic [3:0]  step;
  logic [9:0]  col_addr;
  logic [8:0]  row_addr;
  logic [15:0] rom_addr;
  logic [11:0] rom_data, dout;
  logic        pix_hit, busy, done;

  logic [W-1:0] exp_q[$];
  logic [11:0]  rom_mem [0:1023];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 armed, 2 scrolling, 3 done
  int m_phase, m_pos, m_sel, m_step;

  obstacle_scroller dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .sel(sel), .step(step),
    .col_addr(col_addr), .row_addr(row_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .dout(dout), .pix_hit(pix_hit), .busy(busy), .done(done)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr[9:0]];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pos = 656; m_sel = 0; m_step = 1;
  endtask

  // Sprite left edge sits at screen column 640-pos; rows 115..130 inclusive.
  function automatic int model_addr(input int c, input int r);
    int x;
    if (m_phase == 0) return -1;
    x = 640 - m_pos;
    if (c < x || c >= x + 16 || r < 115 || r > 130) return -1;
    return m_sel * 256 + (r - 115) * 16 + (c - x);
  endfunction

  task automatic model_update(input logic st, input logic tk, input int s, input int sp);
    if (st) begin
      m_phase = 1; m_pos = 0; m_sel = s; m_step = (sp == 0) ? 1 : sp;
    end else begin
      case (m_phase)
        1: if (tk) begin m_pos = m_pos + m_step; m_phase = 2; end
        2: if (tk) begin
             m_pos = (m_pos + m_step > 656) ? 656 : m_pos + m_step;
             if (m_pos == 656) m_phase = 3;
           end
        3: m_phase = 0;
        default: ;
      endcase
    end
  endtask

  task automatic push_expect(input int c, input int r);
    int a;
    logic hit;
    logic [11:0] colr;
    logic [31:0] due;
    a = model_addr(c, r);
    hit = (a >= 0);
    colr = hit ? rom_mem[a] : 12'hfff;
`ifdef OBSTACLE_TRANSPARENT_EN
    if (hit && colr == 12'hfff) hit = 1'b0;
`endif
    if (!hit) colr = 12'hfff;
    due = 32'(cyc + 2);
    exp_q.push_back({due, hit, colr});
  endtask

  // driver: one clock of stimulus, entered and left at posedge+1
  task automatic do_cycle(input logic st, input logic tk, input int s, input int sp,
                          input int c, input int r);
    int a;
    start = st; tick = tk; sel = s[1:0]; step = sp[3:0];
    col_addr = c[9:0]; row_addr = r[8:0];
    push_expect(c, r);
    a = model_addr(c, r);
    #1;
    check("rom_addr", rom_addr, (a < 0) ? 0 : a);
    @(posedge clk);
    model_update(st, tk, s, sp);
    #1;
    start = 1'b0; tick = 1'b0;
    check("busy", busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
    check("done", done, (m_phase == 3) ? 1 : 0);
  endtask

  task automatic rand_pix(output int c, output int r);
    if ($urandom_range(0, 3) == 0) begin
      c = $urandom_range(0, 1023);
      r = $urandom_range(0, 511);
    end else begin
      c = 640 - m_pos + int'($urandom_range(0, 23)) - 4;
      if (c < 0) c = $urandom_range(0, 15);
      if (c > 1023) c = 1023;
      r = $urandom_range(110, 134);
    end
  endtask

  task automatic scan(input int n);
    int c, r;
    for (int i = 0; i < n; i++) begin
      rand_pix(c, r);
      do_cycle(1'b0, 1'b0, 0, 0, c, r);
    end
  endtask

  task automatic tick_cycles(input int n, input int gap);
    int c, r;
    for (int i = 0; i < n; i++) begin
      scan(gap);
      rand_pix(c, r);
      do_cycle(1'b0, 1'b1, 0, 0, c, r);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0][44:13] == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("pix_hit", pix_hit, e[12]);
        check("dout", dout, e[11:0]);
      end
    end
  end

  initial begin
    int c, r, ntick;
    logic st, tk;
    rst = 1'b1; start = 1'b0; tick = 1'b0; sel = '0; step = '0;
    col_addr = '0; row_addr = '0;
    for (int i = 0; i < 1024; i++)
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? 12'hfff : 12'($urandom);
    model_reset();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 12'hfff);
    check("rst_pix_hit", pix_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pos", dut.pos, 656);
    rst = 1'b0;
    scan(20);

    // sel=1 step=4, single tick, probe bottom-left sprite pixel
    do_cycle(1'b1, 1'b0, 1, 4, 0, 0);
    do_cycle(1'b0, 1'b1, 0, 0, 0, 0);
    check("pos_step4", dut.pos, 4);
    do_cycle(1'b0, 1'b0, 0, 0, 636, 130);
    check("rom_addr_636_130", rom_addr, 496);
    scan(6);

    // step=8 to exit
    do_cycle(1'b1, 1'b0, $urandom_range(0, 3), 8, 0, 0);
    ntick = 0;
    while (m_phase != 3 && ntick < 200) begin
      tick_cycles(1, 2);
      ntick++;
    end
    check("ticks_to_exit", ntick, 82);
    scan(12);

    // step=0 behaves as step=1
    do_cycle(1'b1, 1'b0, 2, 0, 0, 0);
    do_cycle(1'b0, 1'b1, 0, 0, 0, 0);
    check("pos_step0", dut.pos, 1);
    scan(4);

    // restart with a coincident tick at pos=300
    do_cycle(1'b1, 1'b0, 0, 15, 0, 0);
    tick_cycles(20, 1);
    check("pos_300", dut.pos, 300);
    do_cycle(1'b1, 1'b1, 3, 5, 340, 120);
    check("restart_pos", dut.pos, 0);
    check("restart_state", int'(dut.state), int'(ARMED));
    tick_cycles(1, 0);
    scan(12);

    // asynchronous reset mid-run with an in-window pixel in flight
    do_cycle(1'b1, 1'b0, 1, 10, 0, 0);
    tick_cycles(20, 1);
    check("pos_200", dut.pos, 200);
    do_cycle(1'b0, 1'b0, 0, 0, 440, 120);
    check("win_d_before_rst", dut.u_pipe.win_d, 1);
    rst = 1'b1;
    #1;
    check("midrst_dout", dout, 12'hfff);
    check("midrst_pix_hit", pix_hit, 0);
    check("midrst_busy", busy, 0);
    check("midrst_win_d", dut.u_pipe.win_d, 0);
    check("midrst_pos", dut.pos, 656);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    scan(6);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      st = (m_phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 79) == 0);
      tk = ($urandom_range(0, 2) == 0);
      rand_pix(c, r);
      do_cycle(st, tk, $urandom_range(0, 3), $urandom_range(0, 15), c, r);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
